// File: rtl/karatsuba_mult_ctrl.sv
// Sequential front end for a combinational Karatsuba multiplier.
// Operands are captured on a valid/ready handshake and held in u_q/v_q, which
// are the only inputs the core ever sees. The core is then given SETTLE cycles
// as a multicycle path before its product is registered and offered on a
// valid/ready output.
//
// state  | meaning
// -------+----------------------------------------------------------
// IDLE   | no operation in flight, ready for an operand pair
// SETTLE | operands held, core output settling, cnt counts down
// HOLD   | product registered on out_r, waiting for out_ready

// One-level Karatsuba multiplier, purely combinational.
// r = z2*2^(2L) + (z1 - z2 - z0)*2^L + z0 with the operands split at bit L.
module karatsuba_core #(
    parameter int N = 16
) (
    input  logic [N-1:0]   u,
    input  logic [N-1:0]   v,
    output logic [2*N-1:0] r
);

    localparam int L = N / 2;
    localparam int H = N - L;

    logic [L-1:0]     u_lo;
    logic [L-1:0]     v_lo;
    logic [H-1:0]     u_hi;
    logic [H-1:0]     v_hi;
    logic [H:0]       u_sum;
    logic [H:0]       v_sum;
    logic [2*L-1:0]   z0;
    logic [2*H-1:0]   z2;
    logic [2*H+1:0]   z1;
    logic [2*H+1:0]   mid;
    logic [2*N-1:0]   mid_ext;

    if (N < 4) begin : g_bad_n
        $error("karatsuba_core: N must be >= 4");
    end

    // Split operands into halves and form the three partial products.
    always_comb begin
        u_lo  = u[L-1:0];
        v_lo  = v[L-1:0];
        u_hi  = u[N-1:L];
        v_hi  = v[N-1:L];
        u_sum = {1'b0, u_hi} + {{(H + 1 - L){1'b0}}, u_lo};
        v_sum = {1'b0, v_hi} + {{(H + 1 - L){1'b0}}, v_lo};
        z0    = {{L{1'b0}}, u_lo} * {{L{1'b0}}, v_lo};
        z2    = {{H{1'b0}}, u_hi} * {{H{1'b0}}, v_hi};
        z1    = {{(H + 1){1'b0}}, u_sum} * {{(H + 1){1'b0}}, v_sum};
    end

    // Recombine: the middle term is the cross product u_hi*v_lo + u_lo*v_hi.
    always_comb begin
        mid     = z1 - {{(2*H + 2 - 2*L){1'b0}}, z0} - {2'b00, z2};
        mid_ext = {{(2*N - 2*H - 2){1'b0}}, mid};
        r       = {z2, z0} + (mid_ext << L);
    end

endmodule

module karatsuba_mult_ctrl #(
    parameter int N      = 16,
    parameter int SETTLE = 2
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [N-1:0]   in_a,
    input  logic [N-1:0]   in_b,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [2*N-1:0] out_r,
    output logic           busy
);

    localparam int CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic [CW-1:0] CNT_INIT = CW'(SETTLE - 1);

    if (SETTLE < 1) begin : g_bad_settle
        $error("karatsuba_mult_ctrl: SETTLE must be >= 1");
    end

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SETTLE = 2'd1,
        S_HOLD   = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [N-1:0]     u_q, u_d;
    logic [N-1:0]     v_q, v_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [2*N-1:0]   out_r_q, out_r_d;
    logic             out_valid_q, out_valid_d;
    logic [2*N-1:0]   core_r;

    karatsuba_core #(
        .N (N)
    ) u_core (
        .u (u_q),
        .v (v_q),
        .r (core_r)
    );

    // State, operand, countdown and result registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            u_q         <= '0;
            v_q         <= '0;
            cnt_q       <= '0;
            out_r_q     <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            u_q         <= u_d;
            v_q         <= v_d;
            cnt_q       <= cnt_d;
            out_r_q     <= out_r_d;
            out_valid_q <= out_valid_d;
        end
    end

    // Next-state logic; operands only move on an accept, so the core inputs
    // stay frozen for the whole settle window and through HOLD.
    always_comb begin
        state_d     = state_q;
        u_d         = u_q;
        v_d         = v_q;
        cnt_d       = cnt_q;
        out_r_d     = out_r_q;
        out_valid_d = out_valid_q;
        in_ready    = 1'b0;
        case (state_q)
            S_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    u_d     = in_a;
                    v_d     = in_b;
                    cnt_d   = CNT_INIT;
                    state_d = S_SETTLE;
                end
            end
            S_SETTLE: begin
                if (cnt_q == '0) begin
                    out_r_d     = core_r;
                    out_valid_d = 1'b1;
                    state_d     = S_HOLD;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            S_HOLD: begin
                // A new pair can only enter on the edge that retires the result.
                in_ready = out_ready;
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    if (in_valid) begin
                        u_d     = in_a;
                        v_d     = in_b;
                        cnt_d   = CNT_INIT;
                        state_d = S_SETTLE;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            default: begin
                state_d     = S_IDLE;
                out_valid_d = 1'b0;
            end
        endcase
    end

    // Registered outputs plus the busy flag.
    always_comb begin
        out_valid = out_valid_q;
        out_r     = out_r_q;
        busy      = (state_q != S_IDLE);
    end

endmodule
